// File: rtl/updown_step_counter.sv
// Up/down step counter: +UP_STEP when mode=1, -DN_STEP when mode=0, with preset/load and one-cycle ovf/unf pulses.
// Define UDSC_SAT_EN to honour the sat input (clamp at the bounds); otherwise the counter always wraps.
module updown_step_counter #(
  parameter int unsigned           WIDTH      = 5,
  parameter int unsigned           UP_STEP    = 3,
  parameter int unsigned           DN_STEP    = 2,
  parameter logic [WIDTH-1:0]      PRESET_VAL = '1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             preset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  input  logic             mode,
  input  logic             sat,
  output logic [WIDTH-1:0] count,
  output logic             ovf,
  output logic             unf
);

  localparam logic [WIDTH:0]   UP_EXT = UP_STEP[WIDTH:0];
  localparam logic [WIDTH-1:0] DN_W   = DN_STEP[WIDTH-1:0];

  logic [WIDTH:0]   up_sum;
  logic             up_ovf;
  logic             dn_unf;
  logic [WIDTH-1:0] dn_diff;
  logic [WIDTH-1:0] up_next;
  logic [WIDTH-1:0] dn_next;

  // The carry out of the WIDTH+1 bit sum is exactly the overflow condition.
  assign up_sum  = {1'b0, count} + UP_EXT;
  assign up_ovf  = up_sum[WIDTH];
  assign dn_unf  = (count < DN_W);
  assign dn_diff = count - DN_W;

`ifdef UDSC_SAT_EN
  assign up_next = (up_ovf && sat) ? {WIDTH{1'b1}} : up_sum[WIDTH-1:0];
  assign dn_next = (dn_unf && sat) ? {WIDTH{1'b0}} : dn_diff;
`else
  logic unused_sat;
  assign unused_sat = sat;
  assign up_next    = up_sum[WIDTH-1:0];
  assign dn_next    = dn_diff;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
      ovf   <= 1'b0;
      unf   <= 1'b0;
    end else if (preset) begin
      count <= PRESET_VAL;
      ovf   <= 1'b0;
      unf   <= 1'b0;
    end else if (load) begin
      count <= load_val;
      ovf   <= 1'b0;
      unf   <= 1'b0;
    end else if (en) begin
      // Flags report the bound crossing even when the value is clamped.
      if (mode) begin
        count <= up_next;
        ovf   <= up_ovf;
        unf   <= 1'b0;
      end else begin
        count <= dn_next;
        ovf   <= 1'b0;
        unf   <= dn_unf;
      end
    end else begin
      ovf <= 1'b0;
      unf <= 1'b0;
    end
  end

endmodule

// File: doc/updown_step_counter.md
# updown_step_counter

Parametrised up/down step counter, the next generation of the lab counter family. Counts up by a fixed step or down by a different fixed step, selected per cycle by `mode`. Adds a count enable, a parallel load, overflow/underflow flags, and optional saturation. Used as a standalone lab block and as a reusable tick/index generator for later counter and timer exercises.

## Interface
- `WIDTH`, 5: counter width in bits, at least 2.
- `UP_STEP`, 3: increment applied when `mode`=1. Range 1 .. 2^WIDTH-1.
- `DN_STEP`, 2: decrement applied when `mode`=0. Range 1 .. 2^WIDTH-1.
- `PRESET_VAL`, all ones: value forced by `preset`. WIDTH bits.
- `clk`  in  1  single clock. Rising edge active.
- `reset`  in  1  asynchronous, active-low reset. Asserted when 0.
- `preset`  in  1  synchronous; loads `PRESET_VAL`.
- `load`  in  1  synchronous; loads `load_val`.
- `load_val`  in  WIDTH  parallel load data.
- `en`  in  1  count enable.
- `mode`  in  1  direction: 1 = up by `UP_STEP`, 0 = down by `DN_STEP`.
- `sat`  in  1  1 = saturate at the bounds, 0 = wrap. Only present in behaviour when `UDSC_SAT_EN` is defined.
- `count`  out  WIDTH  registered counter value.
- `ovf`  out  1  registered overflow flag. One-cycle pulse.
- `unf`  out  1  registered underflow flag. One-cycle pulse.

## Operation
- Priority, highest first: `reset` (async), `preset`, `load`, `en`-gated step, hold.
- `reset`=0:
  - `count`=0, `ovf`=0 and `unf`=0 immediately, with no clock edge required.
  - All three are held while `reset` is low.
- `preset`=1: `count`<=`PRESET_VAL`, regardless of `load`, `en` and `mode`.
- `load`=1 and `preset`=0: `count`<=`load_val`.
- `en`=0 with no load: `count` holds.
- Up step:
  - Sum is computed in WIDTH+1 bits.
  - Overflow when count + UP_STEP > 2^WIDTH-1.
  - Wrap: `count`<=sum mod 2^WIDTH.
  - Saturate: `count`<=2^WIDTH-1.
- Down step:
  - Underflow when count < DN_STEP.
  - Wrap: `count`<=(count - DN_STEP) mod 2^WIDTH.
  - Saturate: `count`<=0.
- Flags:
  - `ovf` is high for exactly the one cycle following an up step that overflowed.
  - `unf` is high for exactly the one cycle following a down step that underflowed.
  - Flags are reported in both wrap and saturate behaviour, including a step taken while already at the bound in saturate.
  - Flags are 0 on any cycle whose update was preset, load or hold.
- `ovf` and `unf` are never high together.

## Timing
- Every synchronous update takes effect on the rising `clk` edge where it is sampled. Latency is 1 cycle.
- `count`, `ovf` and `unf` are direct flop outputs. There is no combinational path from inputs to outputs.
- Reset deassertion is not synchronised internally; the integrating level supplies a synchronised release. The first update happens on the first rising edge with `reset`=1.
- Reset mid-operation clears state asynchronously, including mid-pulse flags.

## Configuration
- `UDSC_SAT_EN` defined:
  - The `sat` port is honoured.
  - `sat`=1 clamps at 0 or 2^WIDTH-1 as described above.
  - `sat`=0 wraps.
- `UDSC_SAT_EN` undefined:
  - The `sat` port exists but is ignored.
  - The counter always wraps modulo 2^WIDTH.
  - No clamp logic is built.

## Test plan
All scenarios use default parameters (WIDTH=5, UP_STEP=3, DN_STEP=2, PRESET_VAL=31).
- Async reset: count=12, drive `reset`=0 between edges -> `count`=0, `ovf`=`unf`=0 before the next edge.
- Up wrap: load 30, then `en`=1, `mode`=1 for one edge -> `count`=1, `ovf`=1 for one cycle, then `count`=4 with `ovf`=0.
- Down wrap: load 1, then `mode`=0 for one edge -> `count`=31, `unf`=1 for one cycle, then `count`=29.
- Saturate (`UDSC_SAT_EN` defined, `sat`=1):
  - Load 30, count up -> `count`=31, `ovf`=1.
  - Count up again -> `count`=31, `ovf`=1.
  - Load 1, count down -> `count`=0, `unf`=1.
- Priority: `preset`=1, `load`=1, `load_val`=9, `en`=1 on the same edge -> `count`=31, flags 0. Next edge with `preset`=0 -> `count`=9.
- Hold: `en`=0 for 5 edges at count=17, with `mode` toggling -> `count` stays 17, flags stay 0.
